hazard_ctrl: RTL and testbench

- Hazard/stall controller for the 5-stage MIPS pipeline. Drives the IF/ID register's write-enable and flush, the PC write-enable, and the ID/EX bubble insert.
- Detects load-use and branch-operand hazards.
- Sequences stalls for a multi-cycle MULT/DIV unit using an internal busy countdown.
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 84 ++++++++
 tb/tb_hazard_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        HZ_NONE    = 3'd0,
        HZ_LOADUSE = 3'd1,
        HZ_BREX    = 3'd2,
        HZ_BRMEM   = 3'd3,
        HZ_MD      = 3'd4
    } hz_cause_t;

    // True when a live source operand reads the producer's destination; $0 never matches.
    function automatic logic regMatch(input logic [4:0] dst, input logic [4:0] src,
                                      input logic uses);
        return uses && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: decode/EX/MEM status in, stall controls out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       idRs;
    logic [4:0]       idRt;
    logic             idUsesRs;
    logic             idUsesRt;
    logic             idBranch;
    logic             branchTaken;
    logic             idIsMd;
    logic             idUsesHiLo;
    logic             exMemRead;
    logic             exRegWrite;
    logic [4:0]       exDst;
    logic             memMemRead;
    logic [4:0]       memDst;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifFlush;
    logic             idexBubble;
    logic             mdBusy;
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output idRs, idRt, idUsesRs, idUsesRt, idBranch, branchTaken, idIsMd, idUsesHiLo,
               exMemRead, exRegWrite, exDst, memMemRead, memDst,
        input  pcWrite, ifidWrite, ifFlush, idexBubble, mdBusy, stallCycles, flushCount
    );

    modport slave (
        input  idRs, idRt, idUsesRs, idUsesRt, idBranch, branchTaken, idIsMd, idUsesHiLo,
               exMemRead, exRegWrite, exDst, memMemRead, memDst,
        output pcWrite, ifidWrite, ifFlush, idexBubble, mdBusy, stallCycles, flushCount
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard detection, MULT/DIV occupancy tracking and
// stall/flush performance counters for the 5-stage pipeline.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    localparam int unsigned MD_W = $clog2(MD_LATENCY + 1);

    logic [MD_W-1:0] md_cnt;
    logic            match_ex;
    logic            match_mem;
    logic            load_use;
    logic            br_ex;
    logic            br_mem;
    logic            md_haz;
    logic            md_busy;
    logic            stall;
    logic            flush;
    logic            issue;
    hz_cause_t       cause;

    assign match_ex  = regMatch(bus.exDst,  bus.idRs, bus.idUsesRs)
                     | regMatch(bus.exDst,  bus.idRt, bus.idUsesRt);
    assign match_mem = regMatch(bus.memDst, bus.idRs, bus.idUsesRs)
                     | regMatch(bus.memDst, bus.idRt, bus.idUsesRt);

    assign md_busy   = (md_cnt != '0);
    assign load_use  = bus.exMemRead & match_ex;
    assign br_ex     = bus.idBranch & bus.exRegWrite & match_ex;
    assign br_mem    = bus.idBranch & bus.memMemRead & match_mem;
    assign md_haz    = md_busy & (bus.idIsMd | bus.idUsesHiLo);

    // Single dominant cause per cycle, so overlapping hazards count as one stall.
    always_comb begin
        cause = HZ_NONE;
        if (md_haz)   cause = HZ_MD;
        if (br_mem)   cause = HZ_BRMEM;
        if (br_ex)    cause = HZ_BREX;
        if (load_use) cause = HZ_LOADUSE;
    end

    assign stall = (cause != HZ_NONE);
    assign flush = bus.branchTaken & ~stall;
    assign issue = bus.idIsMd & ~stall;

    assign bus.pcWrite    = ~stall;
    assign bus.ifidWrite  = ~stall;
    assign bus.idexBubble = stall;
    assign bus.ifFlush    = flush;
    assign bus.mdBusy     = md_busy;

    // Busy countdown: reload on issue, otherwise drain to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt <= '0;
        end else if (issue) begin
            md_cnt <= MD_W'(MD_LATENCY);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (bus.stallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (bus.flushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl with MD_LATENCY=4 and 4-bit counters.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic quiet();
        bus.idRs = 5'd0;        bus.idRt = 5'd0;
        bus.idUsesRs = 1'b0;    bus.idUsesRt = 1'b0;
        bus.idBranch = 1'b0;    bus.branchTaken = 1'b0;
        bus.idIsMd = 1'b0;      bus.idUsesHiLo = 1'b0;
        bus.exMemRead = 1'b0;   bus.exRegWrite = 1'b0;
        bus.exDst = 5'd0;       bus.memMemRead = 1'b0;
        bus.memDst = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_r8();
        bus.exMemRead = 1'b1; bus.exDst = 5'd8;
        bus.idRs = 5'd8;      bus.idUsesRs = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        quiet();
        rst = 1'b1;
        #12;
        chk("rst_pcWrite",    32'(bus.pcWrite),     32'd1);
        chk("rst_ifidWrite",  32'(bus.ifidWrite),   32'd1);
        chk("rst_ifFlush",    32'(bus.ifFlush),     32'd0);
        chk("rst_idexBubble", 32'(bus.idexBubble),  32'd0);
        chk("rst_mdBusy",     32'(bus.mdBusy),      32'd0);
        chk("rst_stall",      32'(bus.stallCycles), 32'd0);
        chk("rst_flush",      32'(bus.flushCount),  32'd0);
        rst = 1'b0;
        tick();

        // load-use on r8
        load_use_r8();
        #1;
        chk("lu_pcWrite",    32'(bus.pcWrite),    32'd0);
        chk("lu_ifidWrite",  32'(bus.ifidWrite),  32'd0);
        chk("lu_idexBubble", 32'(bus.idexBubble), 32'd1);
        tick();
        quiet();
        #1;
        chk("lu_stallcnt", 32'(bus.stallCycles), 32'd1);
        chk("lu_release",  32'(bus.pcWrite),     32'd1);

        // $0 never hazards
        bus.exMemRead = 1'b1; bus.exDst = 5'd0; bus.idRs = 5'd0; bus.idUsesRs = 1'b1;
        #1;
        chk("r0_pcWrite", 32'(bus.pcWrite), 32'd1);
        tick();
        chk("r0_stallcnt", 32'(bus.stallCycles), 32'd1);
        quiet();

        // branch reading a MEM-stage load result
        bus.idBranch = 1'b1; bus.memMemRead = 1'b1; bus.memDst = 5'd5;
        bus.idRs = 5'd5;     bus.idUsesRs = 1'b1;
        #1;
        chk("brmem_bubble", 32'(bus.idexBubble), 32'd1);
        tick();
        chk("brmem_stallcnt", 32'(bus.stallCycles), 32'd2);
        quiet();

        // branch on an ALU result: stall first, flush once operand is ready
        bus.idBranch = 1'b1; bus.branchTaken = 1'b1; bus.exRegWrite = 1'b1;
        bus.exDst = 5'd9;    bus.idRt = 5'd9;        bus.idUsesRt = 1'b1;
        #1;
        chk("brex_ifFlush", 32'(bus.ifFlush),    32'd0);
        chk("brex_bubble",  32'(bus.idexBubble), 32'd1);
        tick();
        chk("brex_stallcnt", 32'(bus.stallCycles), 32'd3);
        bus.exRegWrite = 1'b0; bus.exDst = 5'd0;
        #1;
        chk("brex_flush2",   32'(bus.ifFlush), 32'd1);
        chk("brex_pcWrite2", 32'(bus.pcWrite), 32'd1);
        tick();
        chk("brex_flushcnt", 32'(bus.flushCount),  32'd1);
        chk("brex_stallcnt2", 32'(bus.stallCycles), 32'd3);
        quiet();

        // MULT issue then MFLO waits out the busy window
        bus.idIsMd = 1'b1;
        #1;
        chk("md_issue_pc", 32'(bus.pcWrite), 32'd1);
        tick();
        bus.idIsMd = 1'b0; bus.idUsesHiLo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("md_busy%0d", i),  32'(bus.mdBusy),  32'd1);
            chk($sformatf("md_stall%0d", i), 32'(bus.pcWrite), 32'd0);
            tick();
        end
        chk("md_idle",     32'(bus.mdBusy),      32'd0);
        chk("md_proceed",  32'(bus.pcWrite),     32'd1);
        chk("md_stallcnt", 32'(bus.stallCycles), 32'd7);
        quiet();
        #1;

        // MD issue, then a second MD plus load-use together: one stall per clock
        bus.idIsMd = 1'b1;
        tick();
        load_use_r8();
        tick();
        chk("dual_stallcnt", 32'(bus.stallCycles), 32'd8);
        bus.exMemRead = 1'b0;
        tick();
        chk("md_cnt2_busy", 32'(bus.mdBusy),      32'd1);
        chk("md_cnt2_stall", 32'(bus.stallCycles), 32'd9);

        // asynchronous reset while the countdown is at 2
        #2;
        quiet();
        rst = 1'b1;
        #1;
        chk("arst_mdBusy",  32'(bus.mdBusy),      32'd0);
        chk("arst_stall",   32'(bus.stallCycles), 32'd0);
        chk("arst_flush",   32'(bus.flushCount),  32'd0);
        chk("arst_pcWrite", 32'(bus.pcWrite),     32'd1);
        #1;
        rst = 1'b0;
        tick();

        // saturation of the 4-bit stall counter
        load_use_r8();
        for (int i = 0; i < 15; i++) tick();
        chk("sat_at15", 32'(bus.stallCycles), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", 32'(bus.stallCycles), 32'd15);
        quiet();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
